// File: rtl/opnd_fetch_seq_pkg.sv
// opnd_fetch_seq_pkg
// Shared encodings for the operand fetch sequencer: operand kinds, operand
// sizes, register-file geometry and the sequencer FSM state type.
package opnd_fetch_seq_pkg;

  // Operand slot kind, as carried on opnd_kind.
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_REG  = 2'd1,
    KIND_MEM  = 2'd2,
    KIND_IMM  = 2'd3
  } opnd_kind_t;

  // Operand size, as carried on opnd_size. Code 3 is treated as 32-bit.
  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_32 = 2'd2;

  // Register file: EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI at indices 0..7.
  // With 8-bit size, selectors 4..7 alias AH, CH, DH, BH (bits 15:8 of 0..3).
  localparam int NUM_GPRS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/opnd_fetch_seq_hint_match.sv
// opnd_fetch_seq_hint_match
// Combinational priority matcher: finds the lowest-index read hint whose
// address equals addr.
// Ports:
//   addr          address to look up
//   hint_is_write per-hint write flag (write hints never match)
//   hint_addr     packed hint addresses, lowest index at the lowest slice
//   hint_data     packed hint data, lowest index at the lowest slice
//   hit           some read hint matched
//   hit_idx       index of the winning hint (0 when no hit)
//   hit_data      data of the winning hint (0 when no hit)
module opnd_fetch_seq_hint_match #(
  parameter int NUM_HINTS = 2,
  parameter int DATA_W    = 32,
  parameter int HIDX_W    = (NUM_HINTS > 1) ? $clog2(NUM_HINTS) : 1
) (
  input  logic [DATA_W-1:0]           addr,
  input  logic [NUM_HINTS-1:0]        hint_is_write,
  input  logic [DATA_W*NUM_HINTS-1:0] hint_addr,
  input  logic [DATA_W*NUM_HINTS-1:0] hint_data,
  output logic                        hit,
  output logic [HIDX_W-1:0]           hit_idx,
  output logic [DATA_W-1:0]           hit_data
);

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = NUM_HINTS - 1; i >= 0; i--) begin
      if (!hint_is_write[i] && (hint_addr[i*DATA_W +: DATA_W] == addr)) begin
        hit      = 1'b1;
        hit_idx  = HIDX_W'(i);
        hit_data = hint_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/opnd_fetch_seq.sv
// opnd_fetch_seq
// Operand fetch sequencer. Captures an operand descriptor set on accept,
// then resolves one operand slot per cycle (register, immediate, memory via
// hint lookup, or effective address for LEA-style requests) and presents
// the results until the consumer takes them.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake (accepted in IDLE only)
//   opnd_kind/size/regsel     per-slot descriptor fields
//   opnd_addr / opnd_imm      per-slot effective address / immediate
//   mem_is_phony              MEM slots return address instead of data
//   regs                      register file snapshot, EAX at lowest slice
//   hint_is_write/addr/data   memory hint table
//   out_valid / out_ready     result handshake (held in DONE)
//   opnd_r, hint_used, miss   resolved operands and hint bookkeeping
//   busy                      sequencer not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid until the transfer; ready never
// depends on valid. Result outputs stay stable while out_valid is high and
// keep the last result after the transfer until the next request is accepted.
module opnd_fetch_seq
  import opnd_fetch_seq_pkg::*;
#(
  parameter int NUM_OPNDS = 3,
  parameter int NUM_HINTS = 2,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*NUM_OPNDS-1:0]      opnd_kind,
  input  logic [2*NUM_OPNDS-1:0]      opnd_size,
  input  logic [3*NUM_OPNDS-1:0]      opnd_regsel,
  input  logic [DATA_W*NUM_OPNDS-1:0] opnd_addr,
  input  logic [DATA_W*NUM_OPNDS-1:0] opnd_imm,
  input  logic                        mem_is_phony,
  input  logic [8*DATA_W-1:0]         regs,
  input  logic [NUM_HINTS-1:0]        hint_is_write,
  input  logic [DATA_W*NUM_HINTS-1:0] hint_addr,
  input  logic [DATA_W*NUM_HINTS-1:0] hint_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W*NUM_OPNDS-1:0] opnd_r,
  output logic [NUM_HINTS-1:0]        hint_used,
  output logic                        miss,
  output logic                        busy
);

  localparam int IDX_W  = (NUM_OPNDS > 1) ? $clog2(NUM_OPNDS) : 1;
  localparam int HIDX_W = (NUM_HINTS > 1) ? $clog2(NUM_HINTS) : 1;

  // Zero-extending size mask.
  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    case (sz)
      SIZE_8:  r = {{(DATA_W-8){1'b0}}, v[7:0]};
      SIZE_16: r = {{(DATA_W-16){1'b0}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // Request snapshot; resolution reads only these.
  logic [1:0]                  c_kind   [NUM_OPNDS];
  logic [1:0]                  c_size   [NUM_OPNDS];
  logic [2:0]                  c_regsel [NUM_OPNDS];
  logic [DATA_W-1:0]           c_addr   [NUM_OPNDS];
  logic [DATA_W-1:0]           c_imm    [NUM_OPNDS];
  logic [DATA_W-1:0]           c_regs   [NUM_GPRS];
  logic                        c_phony;
  logic [NUM_HINTS-1:0]        c_hint_is_write;
  logic [DATA_W*NUM_HINTS-1:0] c_hint_addr;
  logic [DATA_W*NUM_HINTS-1:0] c_hint_data;

  logic [DATA_W-1:0] res_q [NUM_OPNDS];

  logic [1:0]        cur_kind;
  logic [1:0]        cur_size;
  logic [2:0]        cur_sel;
  logic [DATA_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_imm;
  logic [DATA_W-1:0] slot_val;
  logic              cur_mem_lookup;

  logic              hm_hit;
  logic [HIDX_W-1:0] hm_idx;
  logic [DATA_W-1:0] hm_data;

  assign accept = in_valid && in_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (in_valid) state_nxt = ST_RESOLVE;
      ST_RESOLVE: if (idx == IDX_W'(NUM_OPNDS - 1)) state_nxt = ST_DONE;
      ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // ---------------- Request capture ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_OPNDS; i++) begin
        c_kind[i]   <= opnd_kind[2*i +: 2];
        c_size[i]   <= opnd_size[2*i +: 2];
        c_regsel[i] <= opnd_regsel[3*i +: 3];
        c_addr[i]   <= opnd_addr[DATA_W*i +: DATA_W];
        c_imm[i]    <= opnd_imm[DATA_W*i +: DATA_W];
      end
      for (int r = 0; r < NUM_GPRS; r++) begin
        c_regs[r] <= regs[DATA_W*r +: DATA_W];
      end
      c_phony         <= mem_is_phony;
      c_hint_is_write <= hint_is_write;
      c_hint_addr     <= hint_addr;
      c_hint_data     <= hint_data;
    end
  end

  // ---------------- Slot resolution ----------------
  opnd_fetch_seq_hint_match #(
    .NUM_HINTS (NUM_HINTS),
    .DATA_W    (DATA_W),
    .HIDX_W    (HIDX_W)
  ) u_hint_match (
    .addr          (cur_addr),
    .hint_is_write (c_hint_is_write),
    .hint_addr     (c_hint_addr),
    .hint_data     (c_hint_data),
    .hit           (hm_hit),
    .hit_idx       (hm_idx),
    .hit_data      (hm_data)
  );

  always_comb begin
    cur_kind       = c_kind[idx];
    cur_size       = c_size[idx];
    cur_sel        = c_regsel[idx];
    cur_addr       = c_addr[idx];
    cur_imm        = c_imm[idx];
    cur_mem_lookup = (opnd_kind_t'(cur_kind) == KIND_MEM) && !c_phony;
    slot_val       = '0;
    case (opnd_kind_t'(cur_kind))
      KIND_REG: begin
        // Byte selectors 4..7 name the high byte of registers 0..3.
        if ((cur_size == SIZE_8) && cur_sel[2])
          slot_val = {{(DATA_W-8){1'b0}}, c_regs[{1'b0, cur_sel[1:0]}][15:8]};
        else
          slot_val = size_mask(c_regs[cur_sel], cur_size);
      end
      KIND_IMM: slot_val = size_mask(cur_imm, cur_size);
      KIND_MEM: begin
        if (c_phony)     slot_val = cur_addr;
        else if (hm_hit) slot_val = size_mask(hm_data, cur_size);
        else             slot_val = '0;
      end
      default: slot_val = '0;
    endcase
  end

  // ---------------- Result registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      hint_used <= '0;
      miss      <= 1'b0;
      for (int i = 0; i < NUM_OPNDS; i++) res_q[i] <= '0;
    end else if (accept) begin
      idx       <= '0;
      hint_used <= '0;
      miss      <= 1'b0;
      for (int i = 0; i < NUM_OPNDS; i++) res_q[i] <= '0;
    end else if (state == ST_RESOLVE) begin
      res_q[idx] <= slot_val;
      if (cur_mem_lookup) begin
        if (hm_hit) hint_used[hm_idx] <= 1'b1;
        else        miss <= 1'b1;
      end
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    opnd_r = '0;
    for (int i = 0; i < NUM_OPNDS; i++) opnd_r[DATA_W*i +: DATA_W] = res_q[i];
  end

endmodule

// File: tb/tb_opnd_fetch_seq.sv
// tb_opnd_fetch_seq
// Bench for opnd_fetch_seq with default parameters (3 slots, 2 hints, 32-bit).
module tb_opnd_fetch_seq;

  typedef struct packed {
    logic [5:0]   kind;
    logic [5:0]   size;
    logic [8:0]   regsel;
    logic [95:0]  addr;
    logic [95:0]  imm;
    logic         phony;
    logic [255:0] regs;
    logic [1:0]   hw;
    logic [63:0]  ha;
    logic [63:0]  hd;
  } req_t;

  typedef struct packed {
    req_t        req;
    logic [95:0] e_opnd;
    logic [1:0]  e_used;
    logic        e_miss;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [5:0]   opnd_kind;
  logic [5:0]   opnd_size;
  logic [8:0]   opnd_regsel;
  logic [95:0]  opnd_addr;
  logic [95:0]  opnd_imm;
  logic         mem_is_phony;
  logic [255:0] regs;
  logic [1:0]   hint_is_write;
  logic [63:0]  hint_addr;
  logic [63:0]  hint_data;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  opnd_r;
  logic [1:0]   hint_used;
  logic         miss;
  logic         busy;

  opnd_fetch_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opnd_kind     (opnd_kind),
    .opnd_size     (opnd_size),
    .opnd_regsel   (opnd_regsel),
    .opnd_addr     (opnd_addr),
    .opnd_imm      (opnd_imm),
    .mem_is_phony  (mem_is_phony),
    .regs          (regs),
    .hint_is_write (hint_is_write),
    .hint_addr     (hint_addr),
    .hint_data     (hint_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opnd_r        (opnd_r),
    .hint_used     (hint_used),
    .miss          (miss),
    .busy          (busy)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Straight from the operand rules: per slot, pick the value by kind, mask
  // by size, and search hints lowest-first for non-phony memory reads.
  function automatic void model(input req_t r, output logic [95:0] o,
                                output logic [1:0] used, output logic m);
    int kind, size, sel, bits, found;
    logic [31:0] v, mask, a;
    o = '0; used = '0; m = 1'b0;
    for (int s = 0; s < 3; s++) begin
      kind = int'(r.kind[2*s +: 2]);
      size = int'(r.size[2*s +: 2]);
      sel  = int'(r.regsel[3*s +: 3]);
      bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
      mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      a    = r.addr[32*s +: 32];
      v    = '0;
      if (kind == 1) begin
        if (bits == 8 && sel >= 4) v = (r.regs[32*(sel-4) +: 32] >> 8) & 32'hFF;
        else                       v = r.regs[32*sel +: 32] & mask;
      end else if (kind == 3) begin
        v = r.imm[32*s +: 32] & mask;
      end else if (kind == 2) begin
        if (r.phony) v = a;
        else begin
          found = -1;
          for (int h = 0; h < 2; h++)
            if (found < 0 && !r.hw[h] && r.ha[32*h +: 32] == a) found = h;
          if (found >= 0) begin
            v = r.hd[32*found +: 32] & mask;
            used[found] = 1'b1;
          end else m = 1'b1;
        end
      end
      o[32*s +: 32] = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input req_t r);
    opnd_kind     = r.kind;
    opnd_size     = r.size;
    opnd_regsel   = r.regsel;
    opnd_addr     = r.addr;
    opnd_imm      = r.imm;
    mem_is_phony  = r.phony;
    regs          = r.regs;
    hint_is_write = r.hw;
    hint_addr     = r.ha;
    hint_data     = r.hd;
  endtask

  task automatic scramble();
    opnd_kind     = 6'($urandom);
    opnd_size     = 6'($urandom);
    opnd_regsel   = 9'($urandom);
    opnd_addr     = {$urandom, $urandom, $urandom};
    opnd_imm      = {$urandom, $urandom, $urandom};
    mem_is_phony  = 1'($urandom);
    regs          = {8{$urandom}};
    hint_is_write = 2'($urandom);
    hint_addr     = {$urandom, $urandom};
    hint_data     = {$urandom, $urandom};
  endtask

  // Issues one request from a negedge, scrambles inputs (with a stray
  // in_valid) while busy, collects the result, holds out_ready low for
  // `hold` cycles (or high from the start when `early`), then releases.
  task automatic run_req(input req_t r, input int hold, input bit early,
                         output logic [95:0] o, output logic [1:0] u,
                         output logic m, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    drive(r);
    in_valid  = 1'b1;
    out_ready = early;
    @(negedge clk);
    scramble();
    in_valid = 1'b1;
    check("accept_busy", busy, 1);
    check("accept_in_ready", in_ready, 0);
    check("accept_clr_opnd", opnd_r, 0);
    check("accept_clr_used", hint_used, 0);
    check("accept_clr_miss", miss, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    o = opnd_r; u = hint_used; m = miss;
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_opnd", opnd_r, o);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_valid", out_valid, 0);
    check("retain_opnd", opnd_r, o);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[6];
  logic [31:0] pool[3];

  task automatic run_and_check(input req_t r, input int hold, input bit early,
                               input logic [95:0] e_o, input logic [1:0] e_u,
                               input logic e_m, input string tag);
    logic [95:0] o; logic [1:0] u; logic m; int lat;
    exp_q.push_back(e_o);
    run_req(r, hold, early, o, u, m, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_opnd"}, o, exp_q.pop_front());
    check({tag, "_used"}, u, e_u);
    check({tag, "_miss"}, m, e_m);
  endtask

  initial begin
    req_t r;
    logic [95:0] e_o; logic [1:0] e_u; logic e_m;

    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;

    // Slot 0 is the lowest slice of every packed per-slot field.
    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // REG ECX 32b, IMM 16b, NONE
    vecs[0].req.kind   = {2'd0, 2'd3, 2'd1};
    vecs[0].req.size   = {2'd0, 2'd1, 2'd2};
    vecs[0].req.regsel = {3'd0, 3'd0, 3'd1};
    vecs[0].req.imm    = {32'h0, 32'hABCD_1234, 32'h0};
    vecs[0].req.regs   = {192'h0, 32'hDEAD_BEEF, 32'h0};
    vecs[0].e_opnd     = {32'h0, 32'h0000_1234, 32'hDEAD_BEEF};
    // MEM hit on the second (read) hint; the first (write) hint at the same address is skipped
    vecs[1].req.kind   = {2'd0, 2'd0, 2'd2};
    vecs[1].req.size   = {2'd0, 2'd0, 2'd2};
    vecs[1].req.addr   = {32'h0, 32'h0, 32'h100};
    vecs[1].req.hw     = 2'b01;
    vecs[1].req.ha     = {32'h100, 32'h100};
    vecs[1].req.hd     = {32'hCAFE_F00D, 32'h1111_1111};
    vecs[1].e_opnd     = {32'h0, 32'h0, 32'hCAFE_F00D};
    vecs[1].e_used     = 2'b10;
    // 8-bit REG: AH then AL
    vecs[2].req.kind   = {2'd0, 2'd1, 2'd1};
    vecs[2].req.regsel = {3'd0, 3'd0, 3'd4};
    vecs[2].req.regs   = {224'h0, 32'h0000_AB12};
    vecs[2].e_opnd     = {32'h0, 32'h12, 32'hAB};
    // MEM miss at 0x200
    vecs[3].req.kind   = {2'd0, 2'd0, 2'd2};
    vecs[3].req.size   = {2'd0, 2'd0, 2'd2};
    vecs[3].req.addr   = {32'h0, 32'h0, 32'h200};
    vecs[3].req.ha     = {32'h104, 32'h100};
    vecs[3].req.hd     = {32'h2222_2222, 32'h3333_3333};
    vecs[3].e_miss     = 1'b1;
    // same request, LEA-style
    vecs[4]            = vecs[3];
    vecs[4].req.phony  = 1'b1;
    vecs[4].e_opnd     = {32'h0, 32'h0, 32'h200};
    vecs[4].e_miss     = 1'b0;
    // 8-bit MEM hit on the first hint masks data; 16-bit REG EDI; size 3 as 32-bit IMM
    vecs[5].req.kind   = {2'd3, 2'd1, 2'd2};
    vecs[5].req.size   = {2'd3, 2'd1, 2'd0};
    vecs[5].req.regsel = {3'd0, 3'd7, 3'd0};
    vecs[5].req.addr   = {32'h0, 32'h0, 32'h104};
    vecs[5].req.imm    = {32'h8765_4321, 32'h0, 32'h0};
    vecs[5].req.regs   = {32'hFEDC_BA98, 224'h0};
    vecs[5].req.ha     = {32'h104, 32'h104};
    vecs[5].req.hd     = {32'h5555_5555, 32'h1234_56F7};
    vecs[5].e_opnd     = {32'h8765_4321, 32'h0000_BA98, 32'h0000_00F7};
    vecs[5].e_used     = 2'b01;

    // clock / reset block
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_opnd", opnd_r, 0);
    check("rst_used", hint_used, 0);
    check("rst_miss", miss, 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 6; i++)
      run_and_check(vecs[i].req, 0, 1'b0, vecs[i].e_opnd, vecs[i].e_used,
                    vecs[i].e_miss, $sformatf("vec%0d", i));

    // consumer stall of 5 cycles, then back-to-back with out_ready held high
    run_and_check(vecs[0].req, 5, 1'b0, vecs[0].e_opnd, 2'b00, 1'b0, "stall");
    run_and_check(vecs[1].req, 0, 1'b1, vecs[1].e_opnd, 2'b10, 1'b0, "b2b_a");
    run_and_check(vecs[3].req, 0, 1'b1, vecs[3].e_opnd, 2'b00, 1'b1, "b2b_b");

    // reset in the second RESOLVE cycle discards the request
    drive(vecs[0].req);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_opnd", opnd_r, 0);
    check("midrst_used", hint_used, 0);
    check("midrst_miss", miss, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    run_and_check(vecs[1].req, 1, 1'b0, vecs[1].e_opnd, 2'b10, 1'b0, "postrst");

    // randomized requests against the reference model
    for (int t = 0; t < 40; t++) begin
      r.kind   = 6'($urandom);
      r.size   = 6'($urandom);
      r.regsel = 9'($urandom);
      r.addr   = {pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)],
                  pool[$urandom_range(0, 2)]};
      r.imm    = {$urandom, $urandom, $urandom};
      r.phony  = ($urandom_range(0, 3) == 0);
      r.regs   = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      r.hw     = 2'($urandom);
      r.ha     = {pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)]};
      r.hd     = {$urandom, $urandom};
      model(r, e_o, e_u, e_m);
      run_and_check(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    e_o, e_u, e_m, $sformatf("rand%0d", t));
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
